ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_pkg.sv | 25 ++
 rtl/ahb_sram_lane_dec.sv | 43 ++++
 rtl/ahb_sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared encodings and sizing constants for the AHB-to-SRAM controller.
package ahb_sram_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int LANES      = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Controller states, kept as plain constants for legacy-compatible encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_DATA  = 3'd1;
    localparam state_t ST_WR_DATA  = 3'd2;
    localparam state_t ST_RD_STALL = 3'd3;
    localparam state_t ST_ERR1     = 3'd4;
    localparam state_t ST_ERR2     = 3'd5;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Decodes HSIZE and the byte offset into a per-lane enable mask plus an
// alignment/size error flag; the mask is zero whenever the error flag is set.
module ahb_sram_lane_dec #(
    parameter int LANES = 4
) (
    input  logic [2:0]       hsize,
    input  logic [1:0]       lane,
    output logic [LANES-1:0] mask,
    output logic             err
);
    import ahb_sram_pkg::*;

    // Lane mask and error decode.
    always_comb begin
        mask = '0;
        err  = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                mask = {{(LANES-1){1'b0}}, 1'b1} << lane;
            end
            HSIZE_HALF: begin
                if (lane[0]) begin
                    err = 1'b1;
                end else if (lane[1]) begin
                    mask = LANES'(4'b1100);
                end else begin
                    mask = LANES'(4'b0011);
                end
            end
            HSIZE_WORD: begin
                if (lane != 2'b00) begin
                    err = 1'b1;
                end else begin
                    mask = '1;
                end
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of LANES byte-wide single-port SRAM macros.
// Reads issue in the address phase, writes in the data phase; a read that lands on a write data phase waits one cycle.
module ahb_sram_ctrl #(
    parameter int ADDR_WIDTH = ahb_sram_pkg::ADDR_WIDTH,
    parameter int LANES      = ahb_sram_pkg::LANES
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [LANES-1:0]      sram_csb,
    output logic [LANES-1:0]      sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_din,
    input  logic [31:0]           sram_dout
);
    import ahb_sram_pkg::*;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LANES-1:0]      mask_r;
    logic [31:0]           hrdata_r;
    logic                  hreadyout_r;
    logic                  hresp_r;

    logic                  accept_s;
    logic                  rd_issue_s;
    logic [LANES-1:0]      dec_mask_s;
    logic                  dec_err_s;
    logic [ADDR_WIDTH-1:0] haddr_word_s;
    logic                  unused_s;

    ahb_sram_lane_dec #(
        .LANES (LANES)
    ) u_lane_dec (
        .hsize (HSIZE),
        .lane  (HADDR[1:0]),
        .mask  (dec_mask_s),
        .err   (dec_err_s)
    );

    // Reset gates acceptance so no SRAM strobe can leak through while it is held.
    assign accept_s     = HSEL & HREADY & HTRANS[1] & hreadyout_r & ~HRESET;
    assign haddr_word_s = HADDR[ADDR_WIDTH+1:2];
    assign rd_issue_s   = accept_s & ~HWRITE & ~dec_err_s & (state_r != ST_WR_DATA);
    assign unused_s     = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_RD_DATA, ST_WR_DATA, ST_ERR2: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (dec_err_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (HWRITE) begin
                    state_nxt_s = ST_WR_DATA;
                end else if (state_r == ST_WR_DATA) begin
                    state_nxt_s = ST_RD_STALL;
                end else begin
                    state_nxt_s = ST_RD_DATA;
                end
            end
            ST_RD_STALL: state_nxt_s = ST_RD_DATA;
            ST_ERR1:     state_nxt_s = ST_ERR2;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // State, captured address phase and registered bus responses.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            mask_r      <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_RD_STALL) && (state_nxt_s != ST_ERR1);
            hresp_r     <= (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
            if (accept_s) begin
                addr_r <= haddr_word_s;
                mask_r <= dec_mask_s;
            end
        end
    end

    // Holds the most recent read word between read data phases.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_r <= 32'h0000_0000;
        end else if (state_r == ST_RD_DATA) begin
            hrdata_r <= sram_dout;
        end
    end

    // SRAM port mux: write data phase, stalled read, or a fresh read straight from the bus.
    always_comb begin
        sram_csb  = '1;
        sram_web  = '1;
        sram_addr = '0;
        sram_din  = 32'h0000_0000;
        case (state_r)
            ST_WR_DATA: begin
                sram_csb  = ~mask_r;
                sram_web  = ~mask_r;
                sram_addr = addr_r;
                sram_din  = HWDATA;
            end
            ST_RD_STALL: begin
                sram_csb  = '0;
                sram_addr = addr_r;
            end
            default: begin
                if (rd_issue_s) begin
                    sram_csb  = '0;
                    sram_addr = haddr_word_s;
                end else begin
                    sram_csb  = '1;
                    sram_addr = '0;
                end
            end
        endcase
    end

    assign HRDATA    = (state_r == ST_RD_DATA) ? sram_dout : hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed scoreboard bench: the driver queues the expected response of every
// address phase it issues and a monitor pops and checks each completed data phase.
module tb_ahb_sram_ctrl;

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] SZ_BYTE   = 3'd0;
    localparam logic [2:0] SZ_HALF   = 3'd1;
    localparam logic [2:0] SZ_WORD   = 3'd2;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [3:0]  sram_csb;
    logic [3:0]  sram_web;
    logic [12:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    assign HREADY = HREADYOUT;

    ahb_sram_ctrl dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 HCLK = ~HCLK;

    // Four byte-wide synchronous SRAM macros.
    logic [31:0] mem [0:8191];
    always @(posedge HCLK) begin
        for (int l = 0; l < 4; l++) begin
            if (!sram_csb[l]) begin
                if (!sram_web[l]) mem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8];
                else              sram_dout[8*l +: 8] <= mem[sram_addr][8*l +: 8];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        bit          err;
        int          waits;
    } exp_t;
    exp_t exp_q[$];

    bit   in_dp        = 1'b0;
    int   mon_waits    = 0;
    bit   wait_resp_lo = 1'b0;
    exp_t cur;

    // Monitor: closes each data phase when HREADYOUT rises and checks it against the queue.
    always @(negedge HCLK) begin
        if (HRESET) begin
            in_dp = 1'b0;
            exp_q.delete();
        end else begin
            if (in_dp) begin
                if (!HREADYOUT) begin
                    mon_waits++;
                    if (!HRESP) wait_resp_lo = 1'b1;
                    if (mon_waits > 8) begin
                        fail_now("data_phase_timeout");
                        in_dp = 1'b0;
                    end
                end else if (exp_q.size() == 0) begin
                    fail_now("unexpected_data_phase");
                    in_dp = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("hresp", {31'd0, HRESP}, {31'd0, cur.err});
                    chk("wait_states", mon_waits, cur.waits);
                    if (cur.err) chk("err_first_cycle_resp", {31'd0, wait_resp_lo}, 32'd0);
                    if (cur.is_read && !cur.err) chk("hrdata", HRDATA, cur.data);
                    in_dp = 1'b0;
                end
            end
            if (HSEL && HREADYOUT && HTRANS[1]) begin
                in_dp        = 1'b1;
                mon_waits    = 0;
                wait_resp_lo = 1'b0;
            end
        end
    end

    int web_run     = 0;
    int web_run_max = 0;
    int csb_low_cnt = 0;

    // Tracks consecutive all-lane write strobes and any chip-select activity.
    always @(negedge HCLK) begin
        if (sram_web == 4'h0) web_run++;
        else                  web_run = 0;
        if (web_run > web_run_max) web_run_max = web_run;
        if (sram_csb != 4'hF) csb_low_cnt++;
    end

    task automatic xfer(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] trans,
                        input bit err, input logic [31:0] rdata, input int waits);
        exp_t e;
        int   n;
        HSEL   = 1'b1;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        e.is_read = !wr;
        e.data    = rdata;
        e.err     = err;
        e.waits   = waits;
        exp_q.push_back(e);
        n = 0;
        @(negedge HCLK);
        while (!HREADYOUT && n < 16) begin
            n++;
            @(negedge HCLK);
        end
        if (!HREADYOUT) fail_now("addr_phase_timeout");
        @(posedge HCLK);
        #1;
        if (wr) HWDATA = wdata;
        HSEL   = 1'b0;
        HTRANS = HT_IDLE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0000_0000;
        HRESET = 1'b1;
        HSEL   = 1'b1;
        HTRANS = HT_NONSEQ;
        HWRITE = 1'b0;
        HSIZE  = SZ_WORD;
        HADDR  = 32'h0000_0040;
        HWDATA = 32'h0000_0000;
        #12;
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0000_0000);
        chk("rst_csb", {28'd0, sram_csb}, 32'h0000_000F);
        chk("rst_web", {28'd0, sram_web}, 32'h0000_000F);
        chk("rst_addr", {19'd0, sram_addr}, 32'h0000_0000);
        chk("rst_din", sram_din, 32'h0000_0000);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Write then conflicting read: one wait state.
        xfer(1'b1, SZ_WORD, 32'h0000_0010, 32'hA5A5_1234, HT_NONSEQ, 1'b0, 32'h0, 0);
        xfer(1'b0, SZ_WORD, 32'h0000_0010, 32'h0, HT_NONSEQ, 1'b0, 32'hA5A5_1234, 1);

        // Byte write into lane 3, idle, read: zero wait states.
        xfer(1'b1, SZ_WORD, 32'h0000_0010, 32'h1122_3344, HT_NONSEQ, 1'b0, 32'h0, 0);
        xfer(1'b1, SZ_BYTE, 32'h0000_0013, 32'hEE5A_5A5A, HT_NONSEQ, 1'b0, 32'h0, 0);
        idle(1);
        xfer(1'b0, SZ_WORD, 32'h0000_0010, 32'h0, HT_NONSEQ, 1'b0, 32'hEE22_3344, 0);

        // Pipelined word writes, then stalled read and back-to-back read.
        web_run     = 0;
        web_run_max = 0;
        xfer(1'b1, SZ_WORD, 32'h0000_0000, 32'h0102_0304, HT_NONSEQ, 1'b0, 32'h0, 0);
        xfer(1'b1, SZ_WORD, 32'h0000_0004, 32'hCAFE_F00D, HT_SEQ, 1'b0, 32'h0, 0);
        xfer(1'b1, SZ_WORD, 32'h0000_0008, 32'h8765_4321, HT_SEQ, 1'b0, 32'h0, 0);
        xfer(1'b0, SZ_WORD, 32'h0000_0004, 32'h0, HT_NONSEQ, 1'b0, 32'hCAFE_F00D, 1);
        xfer(1'b0, SZ_WORD, 32'h0000_0008, 32'h0, HT_NONSEQ, 1'b0, 32'h8765_4321, 0);
        xfer(1'b0, SZ_WORD, 32'h0000_0000, 32'h0, HT_NONSEQ, 1'b0, 32'h0102_0304, 0);
        idle(1);
        chk("web_pulse_run", web_run_max, 32'd3);

        // Error responses, the later two accepted in the second error cycle.
        csb_low_cnt = 0;
        xfer(1'b0, SZ_HALF, 32'h0000_0001, 32'h0, HT_NONSEQ, 1'b1, 32'h0, 1);
        xfer(1'b1, 3'd3,    32'h0000_0000, 32'hFFFF_FFFF, HT_NONSEQ, 1'b1, 32'h0, 1);
        xfer(1'b0, SZ_WORD, 32'h0000_0012, 32'h0, HT_NONSEQ, 1'b1, 32'h0, 1);
        idle(3);
        chk("err_no_csb", csb_low_cnt, 32'd0);
        chk("err_sram_untouched", mem[0], 32'h0102_0304);

        // Reset during a write data phase drops the write.
        xfer(1'b1, SZ_WORD, 32'h0000_0020, 32'h1111_1111, HT_NONSEQ, 1'b0, 32'h0, 0);
        idle(1);
        xfer(1'b1, SZ_WORD, 32'h0000_0020, 32'hDEAD_BEEF, HT_NONSEQ, 1'b0, 32'h0, 0);
        chk("wr_dp_web", {28'd0, sram_web}, 32'h0000_0000);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_mid_web", {28'd0, sram_web}, 32'h0000_000F);
        chk("rst_mid_csb", {28'd0, sram_csb}, 32'h0000_000F);
        chk("rst_mid_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        xfer(1'b0, SZ_WORD, 32'h0000_0020, 32'h0, HT_NONSEQ, 1'b0, 32'h1111_1111, 0);

        // Last word with junk upper address bits.
        xfer(1'b1, SZ_WORD, 32'hABCD_7FFC, 32'h5A5A_C3C3, HT_NONSEQ, 1'b0, 32'h0, 0);
        chk("top_word_addr", {19'd0, sram_addr}, 32'h0000_1FFF);
        idle(1);
        xfer(1'b0, SZ_WORD, 32'h1234_7FFC, 32'h0, HT_NONSEQ, 1'b0, 32'h5A5A_C3C3, 0);
        idle(3);
        chk("hrdata_hold", HRDATA, 32'h5A5A_C3C3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
